// File: rtl/reg_bank_8x16.sv
// Eight-entry register bank with a valid/ready write-back port, a sequenced soft clear
// (one entry per cycle) and a per-entry dirty mask. Q0..Q7 feed the operand-select mux.
module reg_bank_8x16 #(
    parameter int unsigned          WIDTH     = 16,
    parameter bit                   ZERO_R0   = 1'b1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic [7:0]       dirty,
    output logic [WIDTH-1:0] Q0,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2,
    output logic [WIDTH-1:0] Q3,
    output logic [WIDTH-1:0] Q4,
    output logic [WIDTH-1:0] Q5,
    output logic [WIDTH-1:0] Q6,
    output logic [WIDTH-1:0] Q7
);

    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  regs_q [NREG];
    logic [WIDTH-1:0]  regs_d [NREG];
    logic [NREG-1:0]   dirty_q, dirty_d;
    logic              wr_en;

    // Handshake is combinational so a pending clear blocks the write in the same cycle.
    assign busy     = (state_q == CLEAR);
    assign wr_ready = (state_q == IDLE) && !clr_req && !rst;
    assign wr_en    = wr_valid && wr_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        dirty_d = dirty_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                regs_d[cnt_q]  = RESET_VAL;
                dirty_d[cnt_q] = 1'b0;
                cnt_d          = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (wr_en && !(ZERO_R0 && (wr_addr == AW'(0)))) begin
            regs_d[wr_addr]  = wr_data;
            dirty_d[wr_addr] = 1'b1;
        end
        // R0 stays hard-wired even through a clear sweep with a non-zero RESET_VAL.
        if (ZERO_R0) begin
            regs_d[0]  = '0;
            dirty_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= (i == 0 && ZERO_R0) ? '0 : RESET_VAL;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            regs_q  <= regs_d;
        end
    end

    assign dirty = dirty_q;
    assign Q0    = regs_q[0];
    assign Q1    = regs_q[1];
    assign Q2    = regs_q[2];
    assign Q3    = regs_q[3];
    assign Q4    = regs_q[4];
    assign Q5    = regs_q[5];
    assign Q6    = regs_q[6];
    assign Q7    = regs_q[7];

endmodule

// File: tb/tb_reg_bank_8x16.sv
// Directed bench for reg_bank_8x16: reset, writes, R0 protection, soft clear,
// clear/write collision and reset during a clear sweep.
module tb_reg_bank_8x16;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic [7:0]  dirty;
    logic [15:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;

    int n_checks = 0;
    int n_errors = 0;

    reg_bank_8x16 #(.WIDTH(16), .ZERO_R0(1'b1), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .busy(busy), .dirty(dirty),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] q_of(input int idx);
        case (idx)
            0: return Q0;
            1: return Q1;
            2: return Q2;
            3: return Q3;
            4: return Q4;
            5: return Q5;
            6: return Q6;
            default: return Q7;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // T1: reset with a write request held
        rst = 1'b1; wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hFFFF; clr_req = 1'b0;
        step(); step();
        for (int i = 0; i < 8; i++) check_eq($sformatf("t1_q%0d", i), q_of(i), 16'h0000);
        check_eq("t1_dirty", dirty, 8'h00);
        check_eq("t1_busy", busy, 1'b0);
        check_eq("t1_ready_in_rst", wr_ready, 1'b0);
        rst = 1'b0; wr_valid = 1'b0;
        #1;
        check_eq("t1_ready_after_rst", wr_ready, 1'b1);
        step();

        // T2: single write then back-to-back writes
        write_reg(3'd5, 16'hA5C3);
        check_eq("t2_q5", Q5, 16'hA5C3);
        check_eq("t2_dirty_a", dirty, 8'h20);
        wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 16'h0001;
        step();
        wr_addr = 3'd7; wr_data = 16'hFFFF;
        step();
        wr_valid = 1'b0;
        check_eq("t2_q1", Q1, 16'h0001);
        check_eq("t2_q7", Q7, 16'hFFFF);
        check_eq("t2_dirty_b", dirty, 8'hA2);

        // T3: R0 write completes handshake but changes nothing
        wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 16'h1234;
        #1;
        check_eq("t3_ready", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        check_eq("t3_q0", Q0, 16'h0000);
        check_eq("t3_dirty", dirty, 8'hA2);

        // T4: load R1..R7 = 1..7, sweep clear, held write lands after busy falls
        for (int k = 1; k < 8; k++) write_reg(3'(k), 16'(k));
        check_eq("t4_dirty_loaded", dirty, 8'hFE);
        check_eq("t4_q6_loaded", Q6, 16'h0006);
        clr_req = 1'b1;
        #1;
        check_eq("t4_ready_on_req", wr_ready, 1'b0);
        step();
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("t4_busy_c%0d", k), busy, 1'b1);
            check_eq($sformatf("t4_ready_c%0d", k), wr_ready, 1'b0);
            if (k < 7) check_eq($sformatf("t4_q%0d_before", k + 1), q_of(k + 1), 16'(k + 1));
            step();
            check_eq($sformatf("t4_q%0d_cleared", k), q_of(k), 16'h0000);
        end
        check_eq("t4_busy_end", busy, 1'b0);
        check_eq("t4_dirty_end", dirty, 8'h00);
        check_eq("t4_ready_end", wr_ready, 1'b1);
        step();
        wr_valid = 1'b0;
        check_eq("t4_q3_held_write", Q3, 16'hBEEF);
        check_eq("t4_dirty_write", dirty, 8'h08);

        // T5: clear and write in the same cycle, then re-pulse clear mid-sweep
        clr_req = 1'b1; wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 16'h5555;
        step();
        clr_req = 1'b0; wr_valid = 1'b0;
        check_eq("t5_busy", busy, 1'b1);
        check_eq("t5_q2_not_written", Q2, 16'h0000);
        n = 0;
        while (busy && n < 20) begin
            clr_req = (n == 3);
            step();
            n++;
        end
        clr_req = 1'b0;
        check_eq("t5_busy_len", 32'(n), 32'd8);
        check_eq("t5_q3", Q3, 16'h0000);
        check_eq("t5_dirty", dirty, 8'h00);

        // T6: reset asserted at clear cycle 3
        write_reg(3'd6, 16'h6666);
        check_eq("t6_q6_loaded", Q6, 16'h6666);
        pulse_clear();
        step(); step(); step();
        check_eq("t6_busy_mid", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_busy_async", busy, 1'b0);
        check_eq("t6_q6_async", Q6, 16'h0000);
        check_eq("t6_dirty_async", dirty, 8'h00);
        check_eq("t6_ready_async", wr_ready, 1'b0);
        step();
        rst = 1'b0;
        step();
        write_reg(3'd4, 16'h4444);
        check_eq("t6_q4", Q4, 16'h4444);
        check_eq("t6_dirty_end", dirty, 8'h10);
        check_eq("t6_busy_end", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
